ff_excitation_driver: RTL and testbench

- Stimulus side of the flip-flop bank (SR, JK, D, T): accepts a stream of target state words over a valid/ready handshake.
- Converts each word into excitation inputs for all four flop types, using an internally tracked expected state.
- Drives the excitations into the bank for exactly one clock, then checks the bank's returned Q vectors against the target.
- Keeps a sticky error flag and a saturating mismatch counter. Used as the driver/self-checker for flop-bank bring-up and regression.

---
 rtl/ff_pkg.sv | 24 ++
 rtl/ff_excite_lane.sv | 29 ++
 rtl/ff_excitation_driver.sv | 128 ++++++++++++
 tb/tb_ff_excitation_driver.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_pkg.sv
// Shared types for the flip-flop bank excitation driver.
//   state_e : driver FSM states
//   N_DEF   : default lane count
//   exc_t   : excitation bundle for one lane (one flop of each type)
package ff_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StCheck
  } state_e;

  localparam int unsigned N_DEF = 4;

  typedef struct packed {
    logic s;
    logic r;
    logic j;
    logic k;
    logic d;
    logic t;
  } exc_t;

endpackage

// File: rtl/ff_excite_lane.sv
// Per-lane excitation mapping from expected state c and target t.
//   c        : expected (current) state bit
//   t        : target next-state bit
//   drive_en : high while excitations are presented to the bank
//   exc      : SR/JK/D/T excitation for this lane
// With drive_en low every flop holds: S/R/J/K/T are 0 and D re-loads c.
module ff_excite_lane
  import ff_pkg::*;
(
  input  logic c,
  input  logic t,
  input  logic drive_en,
  output exc_t exc
);

  always_comb begin
    exc   = '0;
    exc.d = c;
    if (drive_en) begin
      exc.s = ~c & t;
      exc.r = c & ~t;
      exc.j = ~c & t;
      exc.k = c & ~t;
      exc.t = c ^ t;
      exc.d = t;
    end
  end

endmodule

// File: rtl/ff_excitation_driver.sv
// Stimulus driver and self-checker for an SR/JK/D/T flip-flop bank.
//   clk, rst          : clock, asynchronous active-low reset
//   tgt_valid/ready   : handshake for target state words (tgt_data)
//   s_o..t_o          : excitations, live for exactly one cycle (DRIVE)
//   q_sr..q_t         : bank outputs, compared against expected state in CHECK
//   err_clr           : synchronous clear of err and mismatch_cnt
//   busy, err, mismatch_cnt, chk_done : status
// One word every three cycles: IDLE (accept) -> DRIVE -> CHECK.
module ff_excitation_driver
  import ff_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [N-1:0]     tgt_data,
  output logic             tgt_ready,
  output logic [N-1:0]     s_o,
  output logic [N-1:0]     r_o,
  output logic [N-1:0]     j_o,
  output logic [N-1:0]     k_o,
  output logic [N-1:0]     d_o,
  output logic [N-1:0]     t_o,
  input  logic [N-1:0]     q_sr,
  input  logic [N-1:0]     q_jk,
  input  logic [N-1:0]     q_d,
  input  logic [N-1:0]     q_t,
  input  logic             err_clr,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             chk_done
);

  state_e             state_q, state_d;
  logic [N-1:0]       cur_q, cur_d;
  logic [N-1:0]       tgt_q, tgt_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               mismatch;
  logic               drive_en;
  exc_t               exc [N];

  // Excitations derive only from registered state, so they are stable for
  // the whole DRIVE cycle.
  assign drive_en = (state_q == StDrive);

  for (genvar i = 0; i < N; i++) begin : g_lane
    ff_excite_lane u_lane (
      .c        (cur_q[i]),
      .t        (tgt_q[i]),
      .drive_en (drive_en),
      .exc      (exc[i])
    );
    assign s_o[i] = exc[i].s;
    assign r_o[i] = exc[i].r;
    assign j_o[i] = exc[i].j;
    assign k_o[i] = exc[i].k;
    assign d_o[i] = exc[i].d;
    assign t_o[i] = exc[i].t;
  end

  assign mismatch = |((q_sr ^ cur_q) | (q_jk ^ cur_q) | (q_d ^ cur_q) | (q_t ^ cur_q));

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tgt_valid) begin
          tgt_d   = tgt_data;
          state_d = StDrive;
        end
      end
      StDrive: begin
        // Expected state follows the target, never the observed Q.
        cur_d   = tgt_q;
        state_d = StCheck;
      end
      StCheck: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (mismatch) begin
          err_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // Clear wins over a same-cycle mismatch update.
    if (err_clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cur_q   <= '0;
      tgt_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign tgt_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign err          = err_q;
  assign mismatch_cnt = cnt_q;
  assign chk_done     = done_q;

endmodule

// File: tb/tb_ff_excitation_driver.sv
// Self-checking bench: a behavioural flop bank responds to the driver, and a
// transaction-level model predicts excitations, status and counters.
module tb_ff_excitation_driver;

  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             tgt_valid;
  logic [N-1:0]     tgt_data;
  logic             tgt_ready;
  logic [N-1:0]     s_o, r_o, j_o, k_o, d_o, t_o;
  logic [N-1:0]     q_sr, q_jk, q_d, q_t;
  logic             err_clr;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] mismatch_cnt;
  logic             chk_done;

  ff_excitation_driver #(
    .N     (N),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tgt_valid    (tgt_valid),
    .tgt_data     (tgt_data),
    .tgt_ready    (tgt_ready),
    .s_o          (s_o),
    .r_o          (r_o),
    .j_o          (j_o),
    .k_o          (k_o),
    .d_o          (d_o),
    .t_o          (t_o),
    .q_sr         (q_sr),
    .q_jk         (q_jk),
    .q_d          (q_d),
    .q_t          (q_t),
    .err_clr      (err_clr),
    .busy         (busy),
    .err          (err),
    .mismatch_cnt (mismatch_cnt),
    .chk_done     (chk_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural flop bank; fault_xor corrupts the returned T outputs.
  logic [N-1:0] bq_sr, bq_jk, bq_d, bq_t;
  logic [N-1:0] fault_xor;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bq_sr <= '0;
      bq_jk <= '0;
      bq_d  <= '0;
      bq_t  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (s_o[i]) bq_sr[i] <= 1'b1;
        else if (r_o[i]) bq_sr[i] <= 1'b0;
        case ({j_o[i], k_o[i]})
          2'b10:   bq_jk[i] <= 1'b1;
          2'b01:   bq_jk[i] <= 1'b0;
          2'b11:   bq_jk[i] <= ~bq_jk[i];
          default: bq_jk[i] <= bq_jk[i];
        endcase
        if (t_o[i]) bq_t[i] <= ~bq_t[i];
      end
      bq_d <= d_o;
    end
  end

  assign q_sr = bq_sr;
  assign q_jk = bq_jk;
  assign q_d  = bq_d;
  assign q_t  = bq_t ^ fault_xor;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [N-1:0]     m_cur;
  logic             m_err;
  int               m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected excitations, lane by lane from the transition table.
  task automatic expect_exc(input logic [N-1:0] c, input logic [N-1:0] t,
                            output logic [N-1:0] es, output logic [N-1:0] er,
                            output logic [N-1:0] et);
    es = '0;
    er = '0;
    et = '0;
    for (int i = 0; i < N; i++) begin
      if (c[i] == 1'b0 && t[i] == 1'b1) begin
        es[i] = 1'b1;
        et[i] = 1'b1;
      end else if (c[i] == 1'b1 && t[i] == 1'b0) begin
        er[i] = 1'b1;
        et[i] = 1'b1;
      end
    end
  endtask

  task automatic check_drive(input logic [N-1:0] c, input logic [N-1:0] t);
    logic [N-1:0] es, er, et;
    expect_exc(c, t, es, er, et);
    check("drv_s", 32'(s_o), 32'(es));
    check("drv_r", 32'(r_o), 32'(er));
    check("drv_j", 32'(j_o), 32'(es));
    check("drv_k", 32'(k_o), 32'(er));
    check("drv_t", 32'(t_o), 32'(et));
    check("drv_d", 32'(d_o), 32'(t));
    check("drv_busy", 32'(busy), 32'd1);
    check("drv_ready", 32'(tgt_ready), 32'd0);
  endtask

  task automatic check_status();
    check("st_err", 32'(err), 32'(m_err));
    check("st_cnt", 32'(mismatch_cnt), 32'(m_cnt));
  endtask

  // One full transaction: accept, DRIVE, CHECK, then result.
  task automatic send(input logic [N-1:0] tv, input logic [N-1:0] fx, input bit clr);
    int waitc = 0;
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_data  = tv;
    while (!tgt_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    check("ready_wait", 32'(tgt_ready), 32'd1);
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
    check_drive(m_cur, tv);
    fault_xor = fx;
    @(posedge clk);
    #1;
    m_cur = tv;
    check("chk_d_hold", 32'(d_o), 32'(tv));
    check("chk_no_s", 32'(s_o | r_o | j_o | k_o | t_o), 32'd0);
    check("chk_busy", 32'(busy), 32'd1);
    check("chk_done_early", 32'(chk_done), 32'd0);
    if (clr) err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr   = 1'b0;
    fault_xor = '0;
    if (clr) begin
      m_err = 1'b0;
      m_cnt = 0;
    end else if (fx != '0) begin
      m_err = 1'b1;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    check("done_pulse", 32'(chk_done), 32'd1);
    check("done_ready", 32'(tgt_ready), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check_status();
  endtask

  initial begin
    logic [N-1:0] ta, tb;
    rst       = 1'b0;
    tgt_valid = 1'b0;
    tgt_data  = '0;
    err_clr   = 1'b0;
    fault_xor = '0;
    m_cur     = '0;
    m_err     = 1'b0;
    m_cnt     = 0;

    // Reset values
    #12;
    check("rst_ready", 32'(tgt_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_exc", 32'({s_o, r_o, j_o, k_o, t_o, d_o}), 32'd0);
    check("rst_done", 32'(chk_done), 32'd0);
    check_status();
    @(negedge clk);
    rst = 1'b1;

    // Basic word from cur = 0
    send(4'b1010, '0, 1'b0);

    // Back-to-back with tgt_valid held high
    ta = 4'b1010;
    tb = 4'b0110;
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_data  = ta;
    check("b2b_ready0", 32'(tgt_ready), 32'd1);
    @(posedge clk);
    #1;
    check_drive(m_cur, ta);
    tgt_data = tb;
    @(posedge clk);
    #1;
    m_cur = ta;
    check("b2b_ready1", 32'(tgt_ready), 32'd0);
    @(posedge clk);
    #1;
    check("b2b_ready2", 32'(tgt_ready), 32'd1);
    check("b2b_done1", 32'(chk_done), 32'd1);
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
    check_drive(m_cur, tb);
    check("b2b_s2", 32'(s_o), 32'(4'b0100));
    check("b2b_t2", 32'(t_o), 32'(4'b1100));
    @(posedge clk);
    #1;
    m_cur = tb;
    @(posedge clk);
    #1;
    check("b2b_done2", 32'(chk_done), 32'd1);
    check_status();

    // Repeat target equals cur
    send(4'b0110, '0, 1'b0);

    // Injected mismatch on q_t bit 0, then a clean word
    send(4'b0001, 4'b0001, 1'b0);
    send(4'b1111, '0, 1'b0);
    check("fault_err", 32'(err), 32'd1);
    check("fault_cnt", 32'(mismatch_cnt), 32'd1);

    // Saturation, then clear colliding with a mismatch
    for (int n = 0; n < 300; n++) send(4'($urandom), 4'b0001, 1'b0);
    check("sat_cnt", 32'(mismatch_cnt), 32'd255);
    send(4'($urandom), 4'b0100, 1'b1);
    check("clr_cnt", 32'(mismatch_cnt), 32'd0);
    check("clr_err", 32'(err), 32'd0);

    // Reset in the middle of DRIVE
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_data  = ~m_cur;
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_exc", 32'({s_o, r_o, j_o, k_o, t_o, d_o}), 32'd0);
    check("abort_ready", 32'(tgt_ready), 32'd1);
    check("abort_busy0", 32'(busy), 32'd0);
    m_cur = '0;
    m_err = 1'b0;
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      check("abort_nodone", 32'(chk_done), 32'd0);
    end
    check_status();
    send(4'b0001, '0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [N-1:0] fx;
      fx = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : '0;
      send(4'($urandom), fx, ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
